// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared types and constants for the result frame transmitter
package mm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } state_t;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
  localparam int         ELEM_W       = 16;
  localparam int         FRAME_LEN    = 10;

endpackage

// File: rtl/mm_result_tx_if.sv
// rtl/mm_result_tx_if.sv - byte stream handshake between transmitter and sink
interface mm_result_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/mm_result_tx.sv
// rtl/mm_result_tx.sv - serialises a 2x2 result matrix as header, 8 data bytes, XOR checksum
module mm_result_tx #(
  parameter logic [7:0] HDR_BYTE = mm_pkg::HDR_BYTE_DEF,
  parameter int         ELEM_W   = mm_pkg::ELEM_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*ELEM_W-1:0]   result,
  mm_result_tx_if.master        tx,
  output logic                  busy,
  output logic                  done
);
  import mm_pkg::*;

  state_t              state;
  logic [4*ELEM_W-1:0] shadow;
  logic [2:0]          cnt;
  logic [7:0]          csum;
  logic [7:0]          tx_data_q;
  logic                tx_valid_q;

  logic                xfer;
  logic [2:0]          nxt_cnt;
  logic [7:0]          nxt_byte;

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign xfer        = tx_valid_q & tx.tx_ready;

  // Outputs are registered, so the byte for the next slot is looked up one step ahead.
  always_comb begin
    nxt_cnt  = cnt + 3'd1;
    nxt_byte = shadow[{nxt_cnt, 3'b000} +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      shadow     <= '0;
      cnt        <= 3'd0;
      csum       <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            shadow     <= result;
            csum       <= 8'h00;
            cnt        <= 3'd0;
            tx_data_q  <= HDR_BYTE;
            tx_valid_q <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (xfer) begin
            tx_data_q <= shadow[7:0];
            cnt       <= 3'd0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (xfer) begin
            csum <= csum ^ tx_data_q;
            cnt  <= nxt_cnt;
            // Last data byte: the checksum slot includes the byte leaving now.
            if (cnt == 3'd7) begin
              tx_data_q <= csum ^ tx_data_q;
              state     <= ST_CSUM;
            end else begin
              tx_data_q <= nxt_byte;
            end
          end
        end
        ST_CSUM: begin
          if (xfer) begin
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          tx_data_q  <= 8'h00;
          tx_valid_q <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_result_tx.sv
// tb/tb_mm_result_tx.sv - self-checking bench for mm_result_tx
module tb_mm_result_tx;
  import mm_pkg::*;

  logic        clk;
  logic        rst;
  logic        load;
  logic [63:0] result;
  logic        busy;
  logic        done;

  mm_result_tx_if ifc ();

  mm_result_tx #(.HDR_BYTE(8'hA5), .ELEM_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .result (result),
    .tx     (ifc),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] r;
    logic [7:0]  cs;
    int          stall_idx;
    int          stall_len;
    int          ign_idx;
    int          exp_cyc;
  } vec_t;

  vec_t        vecs[5];
  logic [7:0]  sb[$];
  int          n_tests;
  int          n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [63:0] r, input logic [7:0] cs);
    load   = 1'b1;
    result = r;
    sb.push_back(8'hA5);
    for (int i = 0; i < 8; i++) sb.push_back(r[8*i +: 8]);
    sb.push_back(cs);
  endtask

  // Entered with load already driven; returns in the done cycle (edge + 1).
  task automatic run_frame(input int stall_idx, input int stall_len, input int ign_idx,
                           input int exp_cyc);
    int   cyc;
    int   bidx;
    int   stalled;
    logic ign_done;
    logic got;
    cyc = 0; bidx = 0; stalled = 0; ign_done = 1'b0; got = 1'b0;
    @(posedge clk); #1;
    load = 1'b0;
    cyc  = 1;
    while (cyc < 40) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      chk("busy_in_frame", busy, 1);
      chk("valid_in_frame", ifc.tx_valid, 1);
      load = 1'b0;
      if (ign_idx >= 0 && bidx == ign_idx && !ign_done) begin
        load     = 1'b1;
        result   = 64'h1111_1111_1111_1111;
        ign_done = 1'b1;
      end
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL scoreboard_empty: got byte 0x%0h, expected none", ifc.tx_data);
        ifc.tx_ready = 1'b1;
      end else if (bidx == stall_idx && stalled < stall_len) begin
        ifc.tx_ready = 1'b0;
        chk("stall_hold", ifc.tx_data, sb[0]);
        stalled++;
      end else begin
        ifc.tx_ready = 1'b1;
        chk("byte", ifc.tx_data, sb.pop_front());
        bidx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    load = 1'b0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL frame_timeout: got no done after %0d cycles, expected %0d", cyc, exp_cyc);
    end
    chk("done_cycle", cyc, exp_cyc);
    chk("busy_at_done", busy, 0);
    chk("valid_at_done", ifc.tx_valid, 0);
    chk("data_at_done", ifc.tx_data, 0);
    chk("sb_drained", sb.size(), 0);
    ifc.tx_ready = 1'b0;
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    chk("done_pulse_end", done, 0);
    chk("idle_valid", ifc.tx_valid, 0);
    chk("idle_data", ifc.tx_data, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; load = 1'b0; result = '0; ifc.tx_ready = 1'b0;

    vecs[0] = '{64'h0004_0003_0002_0001, 8'h04, -1, 0, -1, FRAME_LEN + 1};
    vecs[1] = '{64'h0004_0003_0002_0001, 8'h04,  3, 3, -1, FRAME_LEN + 4};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'h00, -1, 0, -1, FRAME_LEN + 1};
    vecs[3] = '{64'h8000_0001_00FF_A55A, 8'h81, -1, 0,  5, FRAME_LEN + 1};
    vecs[4] = '{64'h0102_0304_0506_0708, 8'h08,  9, 2,  2, FRAME_LEN + 3};

    #12;
    chk("rst_valid", ifc.tx_valid, 0);
    chk("rst_data", ifc.tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      do_load(vecs[v].r, vecs[v].cs);
      run_frame(vecs[v].stall_idx, vecs[v].stall_len, vecs[v].ign_idx, vecs[v].exp_cyc);
      idle_check();
    end

    // Back-to-back: load while done is high.
    do_load(vecs[3].r, vecs[3].cs);
    run_frame(-1, 0, -1, FRAME_LEN + 1);
    chk("b2b_done_high", done, 1);
    do_load(vecs[4].r, vecs[4].cs);
    run_frame(-1, 0, -1, FRAME_LEN + 1);
    idle_check();

    // Asynchronous reset in the middle of the data phase.
    do_load(vecs[0].r, vecs[0].cs);
    @(posedge clk); #1;
    load = 1'b0;
    ifc.tx_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_valid", ifc.tx_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", ifc.tx_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_data", ifc.tx_data, 0);
    chk("async_rst_done", done, 0);
    #1 rst = 1'b0;
    sb.delete();
    repeat (5) begin
      @(posedge clk); #1;
      chk("post_rst_quiet", ifc.tx_valid, 0);
    end
    ifc.tx_ready = 1'b0;

    do_load(vecs[0].r, vecs[0].cs);
    run_frame(-1, 0, -1, FRAME_LEN + 1);
    idle_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
